// File: rtl/sirv_qspi_flash_rdseq_pkg.sv
// Shared definitions for the QSPI flash read sequencer: state encoding,
// media-link format codes and the default frame length.
package sirv_qspi_flash_rdseq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DUMMY = 3'd3,
    ST_DATA  = 3'd4,
    ST_CLOSE = 3'd5
  } state_t;

  localparam logic [1:0] PROTO_SINGLE = 2'd0;
  localparam logic [1:0] PROTO_DUAL   = 2'd1;
  localparam logic [1:0] PROTO_QUAD   = 2'd2;

  localparam logic IODIR_RX = 1'b0;
  localparam logic IODIR_TX = 1'b1;

  localparam logic [7:0] FRAME_LEN = 8'd8;

endpackage

// File: rtl/sirv_qspi_flash_rdseq_if.sv
// Request/response and media-link signals of the read sequencer.
// slave = the sequencer, master = requester plus media block.
interface sirv_qspi_flash_rdseq_if;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_addr;
  logic [7:0]  req_len;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic        rsp_last;
  logic        busy;
  logic        link_tx_valid;
  logic        link_tx_ready;
  logic [7:0]  link_tx_bits;
  logic        link_rx_valid;
  logic [7:0]  link_rx_bits;
  logic [7:0]  link_cnt;
  logic [1:0]  link_fmt_proto;
  logic        link_fmt_endian;
  logic        link_fmt_iodir;
  logic        link_cs_set;
  logic        link_cs_clear;
  logic        link_cs_hold;
  logic        link_active;

  modport slave (
    input  req_valid, req_addr, req_len, rsp_ready,
           link_tx_ready, link_rx_valid, link_rx_bits, link_active,
    output req_ready, rsp_valid, rsp_data, rsp_last, busy,
           link_tx_valid, link_tx_bits, link_cnt, link_fmt_proto,
           link_fmt_endian, link_fmt_iodir, link_cs_set, link_cs_clear,
           link_cs_hold
  );

  modport master (
    output req_valid, req_addr, req_len, rsp_ready,
           link_tx_ready, link_rx_valid, link_rx_bits, link_active,
    input  req_ready, rsp_valid, rsp_data, rsp_last, busy,
           link_tx_valid, link_tx_bits, link_cnt, link_fmt_proto,
           link_fmt_endian, link_fmt_iodir, link_cs_set, link_cs_clear,
           link_cs_hold
  );
endinterface

// File: rtl/sirv_qspi_flash_rdseq.sv
// QSPI flash read sequencer: CS open, command, 24-bit address, dummy and data
// frames, CS close; one frame in flight, data returned via a one-entry register.
module sirv_qspi_flash_rdseq
  import sirv_qspi_flash_rdseq_pkg::*;
#(
  parameter logic [7:0] RD_CMD      = 8'h03,
  parameter int         DUMMY_BYTES = 0
) (
  input logic                   clock,
  input logic                   reset,
  sirv_qspi_flash_rdseq_if.slave bus
);

  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_BYTES - 1);

  state_t      state, state_nxt;
  logic [23:0] addr_q;
  logic [7:0]  len_q;
  logic [7:0]  bcnt;
  logic        inflight;
  logic        inflight_data;
  logic        rsp_valid_q;
  logic        rsp_last_q;
  logic [7:0]  rsp_data_q;

  logic        in_xfer;
  logic        tx_valid;
  logic        tx_fire;
  logic        rx_fire;
  logic        rx_data;
  logic        req_ready;
  logic        req_fire;
  logic [7:0]  tx_bits;

  assign in_xfer   = (state == ST_CMD) || (state == ST_ADDR) ||
                     (state == ST_DUMMY) || (state == ST_DATA);
  assign tx_valid  = in_xfer & ~inflight & ~rsp_valid_q;
  assign req_ready = (state == ST_IDLE) & ~bus.link_active;
  assign req_fire  = bus.req_valid & req_ready;
  // rx wins over a coincident tx; an rx with nothing outstanding is ignored
  assign rx_fire   = bus.link_rx_valid & inflight;
  assign rx_data   = rx_fire & inflight_data;
  assign tx_fire   = tx_valid & bus.link_tx_ready & ~bus.link_rx_valid;

  always_comb begin
    state_nxt = state;
    tx_bits   = 8'h00;
    case (state)
      ST_IDLE:  if (req_fire) state_nxt = ST_CMD;
      ST_CMD: begin
        tx_bits = RD_CMD;
        if (tx_fire) state_nxt = ST_ADDR;
      end
      ST_ADDR: begin
        case (bcnt)
          8'd0:    tx_bits = addr_q[23:16];
          8'd1:    tx_bits = addr_q[15:8];
          default: tx_bits = addr_q[7:0];
        endcase
        if (tx_fire && bcnt == 8'd2)
          state_nxt = (DUMMY_BYTES > 0) ? ST_DUMMY : ST_DATA;
      end
      ST_DUMMY: if (tx_fire && bcnt == DUMMY_LAST) state_nxt = ST_DATA;
      ST_DATA:  if (rx_data && bcnt == len_q) state_nxt = ST_CLOSE;
      ST_CLOSE: if ((~rsp_valid_q | bus.rsp_ready) & ~bus.link_active)
                  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      addr_q        <= '0;
      len_q         <= '0;
      bcnt          <= '0;
      inflight      <= 1'b0;
      inflight_data <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_last_q    <= 1'b0;
      rsp_data_q    <= '0;
    end else begin
      state <= state_nxt;
      if (req_fire) begin
        addr_q <= bus.req_addr;
        len_q  <= bus.req_len;
      end
      // bcnt counts tx frames in header phases and rx bytes in DATA
      if (state_nxt != state)
        bcnt <= '0;
      else if (tx_fire && state != ST_DATA)
        bcnt <= bcnt + 8'd1;
      else if (rx_data)
        bcnt <= bcnt + 8'd1;
      // tag the outstanding frame so a late header rx never lands as data
      if (rx_fire) begin
        inflight      <= 1'b0;
        inflight_data <= 1'b0;
      end else if (tx_fire) begin
        inflight      <= 1'b1;
        inflight_data <= (state == ST_DATA);
      end
      if (rx_data) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= bus.link_rx_bits;
        rsp_last_q  <= (bcnt == len_q);
      end else if (rsp_valid_q && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready       = req_ready;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_data        = rsp_data_q;
  assign bus.rsp_last        = rsp_last_q;
  assign bus.busy            = (state != ST_IDLE) | bus.link_active;
  assign bus.link_tx_valid   = tx_valid;
  assign bus.link_tx_bits    = tx_bits;
  assign bus.link_cnt        = FRAME_LEN;
  assign bus.link_fmt_proto  = PROTO_SINGLE;
  assign bus.link_fmt_endian = 1'b0;
  assign bus.link_fmt_iodir  = ((state == ST_CMD) || (state == ST_ADDR) ||
                                (state == ST_DUMMY)) ? IODIR_TX : IODIR_RX;
  assign bus.link_cs_set     = (state != ST_IDLE);
  assign bus.link_cs_clear   = (state == ST_CLOSE);
  assign bus.link_cs_hold    = in_xfer;

endmodule
